sysid_access_ctrl: RTL

//  Sequences and shares the read-only system-ID slave (32-bit readdata, 1-bit address, combinational).

---
 rtl/sysid_access_ctrl_if.sv | 27 ++
 rtl/sysid_access_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/sysid_access_ctrl_if.sv
// Requester-side read bus for the shared system-ID slave.
// Level request per requester, one-hot grant, one-hot return valid.
interface sysid_access_ctrl_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_addr;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rvalid;
    logic [31:0]      rdata;

    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/sysid_access_ctrl.sv
// Self-checks the system-ID slave after reset, then shares it
// round-robin between requesters with registered return data.
module sysid_access_ctrl #(
    parameter int          N_REQ       = 2,
    parameter logic [31:0] EXPECTED_ID = 32'h00000000,
    parameter logic [31:0] EXPECTED_TS = 32'h4F2B4ED0,
    parameter int          MAX_RETRY   = 3
) (
    input  logic                clock,
    input  logic                reset,
    output logic                sysid_address,
    input  logic [31:0]         sysid_readdata,
    sysid_access_ctrl_if.slave  bus,
    output logic                check_done,
    output logic                id_ok,
    output logic                id_err,
    output logic [2:0]          retry_cnt
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        CHK_ID,
        CHK_TS,
        RETRY,
        SERVE
    } state_t;

    state_t           state;
    logic             id_match;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    sel;
    logic             any;
    logic [PW:0]      j;
    logic [N_REQ-1:0] gnt_vec;
    logic             ts_now;

    // First asserted request at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        sel = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = {1'b0, rr_ptr} + (PW+1)'(i);
            if (j >= (PW+1)'(N_REQ)) j = j - (PW+1)'(N_REQ);
            if (!any && bus.req[j[PW-1:0]]) begin
                any = 1'b1;
                sel = j[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (state == SERVE && any) gnt_vec[sel] = 1'b1;
    end

    always_comb begin
        sysid_address = 1'b0;
        unique case (state)
            CHK_TS:  sysid_address = 1'b1;
            SERVE:   sysid_address = any ? bus.req_addr[sel] : 1'b0;
            default: sysid_address = 1'b0;
        endcase
    end

    assign bus.gnt = gnt_vec;
    assign ts_now  = (sysid_readdata == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CHK_ID;
            id_match   <= 1'b0;
            rr_ptr     <= '0;
            bus.rvalid <= '0;
            bus.rdata  <= '0;
            check_done <= 1'b0;
            id_ok      <= 1'b0;
            id_err     <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            bus.rvalid <= '0;
            unique case (state)
                CHK_ID: begin
                    id_match <= (sysid_readdata == EXPECTED_ID);
                    state    <= CHK_TS;
                end
                CHK_TS: begin
                    if (id_match && ts_now) begin
                        state      <= SERVE;
                        id_ok      <= 1'b1;
                        check_done <= 1'b1;
                    end else if (retry_cnt < 3'(MAX_RETRY)) begin
                        state     <= RETRY;
                        retry_cnt <= retry_cnt + 3'd1;
                    end else begin
                        state      <= SERVE;
                        id_err     <= 1'b1;
                        check_done <= 1'b1;
                    end
                end
                RETRY: state <= CHK_ID;
                SERVE: begin
                    if (any) begin
                        bus.rdata  <= sysid_readdata;
                        bus.rvalid <= gnt_vec;
                        rr_ptr     <= (sel == PW'(N_REQ - 1)) ? '0
                                                              : sel + PW'(1);
                    end
                end
                default: state <= CHK_ID;
            endcase
        end
    end
endmodule
